csr_access_unit: RTL and testbench



---
 rtl/csr_access_unit_if.sv | 35 +++
 rtl/csr_access_unit.sv | 126 ++++++++++++
 tb/tb_csr_access_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_unit_if.sv
// Request/response handshake bundle between the execute stage
// and the CSR access sequencer.
interface csr_access_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_csr;
  logic [XLEN-1:0] req_rs1_val;
  logic [4:0]      req_rs1_idx;
  logic [4:0]      req_rd;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_rd;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_we;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_csr,
    output req_rs1_val, req_rs1_idx, req_rd,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rd,
    input  rsp_data, rsp_we, rsp_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_csr,
    input  req_rs1_val, req_rs1_idx, req_rd,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rd,
    output rsp_data, rsp_we, rsp_illegal
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer between execute and the CSR file.
// One op at a time: IDLE -> READ -> EXEC -> RESP.
module csr_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  csr_access_unit_if.slave bus,
  output logic            csr_ren,
  output logic            csr_wr_en,
  output logic [11:0]     addr,
  output logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] rdata,
  input  logic            trap_detected
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    RESP
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] src_q;
  logic [11:0]     csr_q;
  logic [4:0]      rd_q;
  logic            ill_q;
  logic            rsup_q;
  logic            wsup_q;
  logic [XLEN-1:0] data_q;
  logic            we_q;
  logic            ill_rsp_q;

  logic [1:0]      op_d;
  logic            rsup_d;
  logic            wsup_d;
  logic            ill_d;
  logic [XLEN-1:0] src_d;
  logic [XLEN-1:0] new_val;
  logic            accept;

  assign op_d   = bus.req_funct3[1:0];
  assign rsup_d = (op_d == 2'b01) && (bus.req_rd == 5'd0);
  assign wsup_d = (op_d != 2'b01) && (bus.req_rs1_idx == 5'd0);
  // A write into the read-only quadrant is only illegal if it happens
  assign ill_d  = (op_d == 2'b00)
               || (!wsup_d && (bus.req_csr[11:10] == 2'b11));
  assign src_d  = bus.req_funct3[2]
               ? {{(XLEN-5){1'b0}}, bus.req_rs1_idx}
               : bus.req_rs1_val;

  always_comb begin
    new_val = src_q;
    case (op_q)
      2'b10:   new_val = rdata | src_q;
      2'b11:   new_val = rdata & ~src_q;
      default: new_val = src_q;
    endcase
  end

  assign bus.req_ready = rst && (state == IDLE) && !trap_detected;
  assign accept        = bus.req_valid && bus.req_ready;

  assign csr_ren   = (state == READ) && !rsup_q && !ill_q;
  assign csr_wr_en = (state == EXEC) && !wsup_q && !ill_q
                  && !trap_detected;
  assign addr      = (state == READ || state == EXEC) ? csr_q : '0;
  assign wr_data   = (state == EXEC) ? new_val : '0;

  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_rd      = rd_q;
  assign bus.rsp_data    = data_q;
  assign bus.rsp_we      = we_q;
  assign bus.rsp_illegal = ill_rsp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= '0;
      src_q     <= '0;
      csr_q     <= '0;
      rd_q      <= '0;
      ill_q     <= 1'b0;
      rsup_q    <= 1'b0;
      wsup_q    <= 1'b0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ill_rsp_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= READ;
            op_q   <= op_d;
            src_q  <= src_d;
            csr_q  <= bus.req_csr;
            rd_q   <= bus.req_rd;
            ill_q  <= ill_d;
            rsup_q <= rsup_d;
            wsup_q <= wsup_d;
          end
        end
        READ: begin
          state <= trap_detected ? IDLE : EXEC;
        end
        EXEC: begin
          if (trap_detected) begin
            state <= IDLE;
          end else begin
            state     <= RESP;
            data_q    <= (ill_q || rsup_q) ? '0 : rdata;
            we_q      <= !ill_q && !rsup_q && (rd_q != 5'd0);
            ill_rsp_q <= ill_q;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR file model.
// 0xF14 reads back a fixed id value.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csr_ren;
  logic        csr_wr_en;
  logic [11:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rdata = '0;
  logic        trap_detected = 1'b0;

  logic [31:0] mem [0:4095] = '{default: 32'h0};

  int passed = 0;
  int total  = 0;

  int          ren_cyc, wr_cyc, rsp_cyc;
  int          nren, nwr, nrsp, overlap;
  logic [31:0] wr_val;
  logic        stable;

  csr_access_unit_if #(.XLEN(32)) bus ();

  csr_access_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .csr_ren       (csr_ren),
    .csr_wr_en     (csr_wr_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .rdata         (rdata),
    .trap_detected (trap_detected)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (csr_ren)
      rdata <= (addr == 12'hF14) ? 32'h1234 : mem[addr];
    if (csr_wr_en)
      mem[addr] <= wr_data;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic accept(input logic [2:0]  f3,
                        input logic [11:0] c,
                        input logic [31:0] v,
                        input logic [4:0]  idx,
                        input logic [4:0]  rd);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_funct3  = f3;
    bus.req_csr     = c;
    bus.req_rs1_val = v;
    bus.req_rs1_idx = idx;
    bus.req_rd      = rd;
    bus.req_valid   = 1'b1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic observe();
    ren_cyc = 0; wr_cyc = 0; rsp_cyc = 0;
    nren = 0; nwr = 0; overlap = 0; wr_val = '0;
    for (int k = 1; k <= 12 && rsp_cyc == 0; k++) begin
      @(negedge clk);
      if (csr_ren) begin
        nren++;
        if (ren_cyc == 0) ren_cyc = k;
      end
      if (csr_wr_en) begin
        nwr++;
        wr_cyc = k;
        wr_val = wr_data;
      end
      if (csr_ren && csr_wr_en) overlap++;
      if (bus.rsp_valid) rsp_cyc = k;
    end
    if (rsp_cyc == 0) check("rsp_timeout", 0, 1);
  endtask

  task automatic watch(input int n);
    nwr = 0; nrsp = 0;
    repeat (n) begin
      @(negedge clk);
      if (csr_wr_en) nwr++;
      if (bus.rsp_valid) nrsp++;
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_funct3  = '0;
    bus.req_csr     = '0;
    bus.req_rs1_val = '0;
    bus.req_rs1_idx = '0;
    bus.req_rd      = '0;
    bus.rsp_ready   = 1'b1;

    #12;
    check("rst_req_ready", {31'b0, bus.req_ready}, 0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    check("rst_strobes", {30'b0, csr_ren, csr_wr_en}, 0);
    check("rst_addr", {20'b0, addr}, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // CSRRW 0x300 <- 8, rd=5
    accept(3'b001, 12'h300, 32'h8, 5'd1, 5'd5);
    observe();
    check("rw_ren_cyc", ren_cyc, 1);
    check("rw_wr_cyc", wr_cyc, 2);
    check("rw_wr_data", wr_val, 32'h8);
    check("rw_rsp_cyc", rsp_cyc, 3);
    check("rw_rsp_rd", {27'b0, bus.rsp_rd}, 5);
    check("rw_rsp_data", bus.rsp_data, 0);
    check("rw_rsp_we", {31'b0, bus.rsp_we}, 1);
    check("rw_overlap", overlap, 0);
    check("rw_mie", {31'b0, mem[12'h300][3]}, 1);

    // CSRRS 0x80
    accept(3'b010, 12'h300, 32'h80, 5'd2, 5'd6);
    observe();
    check("rs_wr_data", wr_val, 32'h88);
    check("rs_rsp_data", bus.rsp_data, 32'h8);
    check("rs_nwr", nwr, 1);

    // CSRRCI uimm=8
    accept(3'b111, 12'h300, 32'hFFFF_FFFF, 5'd8, 5'd7);
    observe();
    check("rci_wr_data", wr_val, 32'h80);
    check("rci_rsp_data", bus.rsp_data, 32'h88);
    check("rci_rsp_rd", {27'b0, bus.rsp_rd}, 7);

    // CSRRS with rs1=x0 reads only
    accept(3'b010, 12'h300, 32'hFF, 5'd0, 5'd3);
    observe();
    check("rs0_nwr", nwr, 0);
    check("rs0_ren_cyc", ren_cyc, 1);
    check("rs0_rsp_data", bus.rsp_data, 32'h80);
    check("rs0_rsp_we", {31'b0, bus.rsp_we}, 1);

    // CSRRW with rd=x0 writes only
    accept(3'b001, 12'h300, 32'h5, 5'd4, 5'd0);
    observe();
    check("rwx0_nren", nren, 0);
    check("rwx0_nwr", nwr, 1);
    check("rwx0_wr_data", wr_val, 32'h5);
    check("rwx0_rsp_we", {31'b0, bus.rsp_we}, 0);
    check("rwx0_rsp_data", bus.rsp_data, 0);
    check("rwx0_mem", mem[12'h300], 32'h5);

    // write to read-only space
    accept(3'b001, 12'hF14, 32'h1, 5'd1, 5'd2);
    observe();
    check("ro_strobes", nren + nwr, 0);
    check("ro_rsp_cyc", rsp_cyc, 3);
    check("ro_illegal", {31'b0, bus.rsp_illegal}, 1);
    check("ro_rsp_we", {31'b0, bus.rsp_we}, 0);
    check("ro_rsp_data", bus.rsp_data, 0);

    // reserved funct3
    accept(3'b100, 12'h300, 32'h1, 5'd1, 5'd2);
    observe();
    check("f100_illegal", {31'b0, bus.rsp_illegal}, 1);
    check("f100_strobes", nren + nwr, 0);

    // read-only CSR read is legal
    accept(3'b010, 12'hF14, 32'h1, 5'd0, 5'd4);
    observe();
    check("roread_illegal", {31'b0, bus.rsp_illegal}, 0);
    check("roread_data", bus.rsp_data, 32'h1234);
    check("roread_we", {31'b0, bus.rsp_we}, 1);

    // trap during READ
    accept(3'b001, 12'h340, 32'hAA, 5'd1, 5'd1);
    trap_detected = 1'b1;
    @(negedge clk);
    check("trapr_wr_en", {31'b0, csr_wr_en}, 0);
    @(posedge clk);
    #1 trap_detected = 1'b0;
    @(negedge clk);
    check("trapr_req_ready", {31'b0, bus.req_ready}, 1);
    watch(4);
    check("trapr_nwr", nwr, 0);
    check("trapr_nrsp", nrsp, 0);
    check("trapr_mem", mem[12'h340], 0);

    // trap during EXEC
    accept(3'b001, 12'h341, 32'h55, 5'd1, 5'd1);
    @(posedge clk);
    #1 trap_detected = 1'b1;
    @(negedge clk);
    check("trape_wr_en", {31'b0, csr_wr_en}, 0);
    @(posedge clk);
    #1 trap_detected = 1'b0;
    watch(3);
    check("trape_nrsp", nrsp, 0);
    check("trape_mem", mem[12'h341], 0);

    // consumer stall
    bus.rsp_ready = 1'b0;
    accept(3'b010, 12'h300, 32'h0, 5'd0, 5'd9);
    observe();
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== 32'h5
          || bus.req_ready || bus.rsp_rd !== 5'd9)
        stable = 1'b0;
    end
    check("stall_stable", {31'b0, stable}, 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {31'b0, bus.rsp_valid}, 0);

    // async reset during EXEC
    accept(3'b001, 12'h300, 32'h77, 5'd1, 5'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstx_strobes", {30'b0, csr_ren, csr_wr_en}, 0);
    check("rstx_wr_data", wr_data, 0);
    check("rstx_addr", {20'b0, addr}, 0);
    check("rstx_ready_valid",
          {30'b0, bus.req_ready, bus.rsp_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rstx_mem", mem[12'h300], 32'h5);

    accept(3'b001, 12'h300, 32'h9, 5'd1, 5'd2);
    observe();
    check("post_rsp_data", bus.rsp_data, 32'h5);
    check("post_wr_data", wr_val, 32'h9);
    check("post_rsp_cyc", rsp_cyc, 3);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
